// File: rtl/prio_enc16.sv
// Sequential 16-to-4 priority encoder: captures active-low requests into a sticky
// pending mask and returns one index at a time over a valid/ready handshake.
module prio_enc16 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [0:15] Yn,
  input  logic        ready,
  output logic [3:0]  W,
  output logic        valid,
  output logic [0:15] pend
);

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [0:N-1]    pend_q, pend_d;

  logic            hs;
  logic [0:N-1]    cand;
  logic [IW-1:0]   start;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   sel;
  logic            found;

  // Candidate search, pending-mask update and next-state decode
  always_comb begin
    hs    = (state_q == S_PRESENT) && ready;
    cand  = pend_q;
    if (state_q == S_PRESENT) cand[w_q] = 1'b0;

    // Scan origin: round-robin resumes after the last grant (the one being retired when presenting)
    if (ROUND_ROBIN) start = (state_q == S_PRESENT) ? w_q + IW'(1) : ptr_q + IW'(1);
    else             start = '0;

    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = start + IW'(k);
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end

    // Capture is applied after the clear so a same-edge re-request keeps the bit set
    pend_d = pend_q;
    if (hs) pend_d[w_q] = 1'b0;
    if (En) pend_d = pend_d | ~Yn;

    state_d = state_q;
    w_d     = w_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_PRESENT;
          w_d     = sel;
          valid_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (ready) begin
          ptr_d = w_q;
          if (found) begin
            w_d = sel;
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      ptr_q   <= IW'(N - 1);
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign W     = w_q;
  assign valid = valid_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_prio_enc16.sv
// Bench for prio_enc16: fixed-priority and round-robin instances share stimulus and are
// checked against an index-level reference model plus directed expectation tables.
module tb_prio_enc16;

  logic        clk = 1'b0;
  logic        reset, En, ready;
  logic [0:15] Yn;
  logic [3:0]  w0, w1;
  logic        v0, v1;
  logic [0:15] p0, p1;

  int n_cmp = 0;
  int n_err = 0;

  logic        cur_rst, cur_en, cur_rdy;
  logic [15:0] cur_req;

  logic [15:0] m_pend [2];
  logic        m_valid[2];
  logic [3:0]  m_w    [2];
  int          m_ptr  [2];

  typedef struct {
    int          rst;
    int          en;
    logic [15:0] req;
    int          rdy;
    int          rep;
    int          ev;
    int          ew;
    int          chkw;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl[$];

  prio_enc16 #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .En(En), .Yn(Yn), .ready(ready),
    .W(w0), .valid(v0), .pend(p0)
  );

  prio_enc16 #(.ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .En(En), .Yn(Yn), .ready(ready),
    .W(w1), .valid(v1), .pend(p1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] norm(input logic [0:15] p);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [0:15] to_yn(input logic [15:0] req);
    logic [0:15] y;
    for (int i = 0; i < 16; i++) y[i] = ~req[i];
    return y;
  endfunction

  // First set index strictly after 'after', wrapping modulo 16
  function automatic int pick(input logic [15:0] c, input int after);
    for (int k = 1; k <= 16; k++) begin
      if (c[(after + k) % 16]) return (after + k) % 16;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [15:0] p, newp, cand;
    logic        hs;
    int          after;
    for (int r = 0; r < 2; r++) begin
      if (cur_rst) begin
        m_pend[r]  = 16'h0;
        m_valid[r] = 1'b0;
        m_w[r]     = 4'd0;
        m_ptr[r]   = 15;
      end else begin
        p    = m_pend[r];
        hs   = m_valid[r] && cur_rdy;
        newp = p;
        if (hs) newp[m_w[r]] = 1'b0;
        if (cur_en) newp = newp | cur_req;
        if (!m_valid[r]) begin
          if (p != 16'h0) begin
            after      = (r == 1) ? m_ptr[r] : 15;
            m_w[r]     = 4'(pick(p, after));
            m_valid[r] = 1'b1;
          end
        end else if (hs) begin
          cand     = p & ~(16'd1 << m_w[r]);
          m_ptr[r] = int'(m_w[r]);
          if (cand != 16'h0) begin
            after  = (r == 1) ? int'(m_w[r]) : 15;
            m_w[r] = 4'(pick(cand, after));
          end else begin
            m_valid[r] = 1'b0;
          end
        end
        m_pend[r] = newp;
      end
    end
  endtask

  task automatic model_check();
    chk("model_valid0", 32'(v0), 32'(m_valid[0]));
    chk("model_pend0",  32'(norm(p0)), 32'(m_pend[0]));
    if (m_valid[0]) chk("model_W0", 32'(w0), 32'(m_w[0]));
    chk("model_valid1", 32'(v1), 32'(m_valid[1]));
    chk("model_pend1",  32'(norm(p1)), 32'(m_pend[1]));
    if (m_valid[1]) chk("model_W1", 32'(w1), 32'(m_w[1]));
  endtask

  task automatic step(input logic rst, input logic en, input logic [15:0] req, input logic rdy);
    reset   = rst;
    En      = en;
    Yn      = to_yn(req);
    ready   = rdy;
    cur_rst = rst;
    cur_en  = en;
    cur_req = req;
    cur_rdy = rdy;
    @(posedge clk);
    #1;
    model_update();
    model_check();
  endtask

  initial begin
    reset = 1'b1; En = 1'b0; Yn = '1; ready = 1'b0;

    // Directed vectors for the fixed-priority instance
    tbl.push_back('{1, 1, 16'h0,    1,  2, 0,  0, 1, 16'h0});
    tbl.push_back('{0, 1, 16'h0020, 1,  1, 0,  0, 0, 16'h0020});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1,  5, 1, 16'h0020});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 0,  0, 0, 16'h0});
    tbl.push_back('{0, 1, 16'h4204, 1,  1, 0,  0, 0, 16'h4204});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1,  2, 1, 16'h4204});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1,  9, 1, 16'h4200});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1, 14, 1, 16'h4000});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 0,  0, 0, 16'h0});
    tbl.push_back('{0, 1, 16'h0088, 0,  1, 0,  0, 0, 16'h0088});
    tbl.push_back('{0, 1, 16'h0,    0, 10, 1,  3, 1, 16'h0088});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1,  7, 1, 16'h0080});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 0,  0, 0, 16'h0});
    tbl.push_back('{0, 0, 16'hFFFF, 1,  3, 0,  0, 0, 16'h0});
    tbl.push_back('{0, 1, 16'h0010, 0,  1, 0,  0, 0, 16'h0010});
    tbl.push_back('{0, 1, 16'h0,    0,  1, 1,  4, 1, 16'h0010});
    tbl.push_back('{0, 1, 16'h0010, 1,  1, 0,  0, 0, 16'h0010});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 1,  4, 1, 16'h0010});
    tbl.push_back('{0, 1, 16'h0,    1,  1, 0,  0, 0, 16'h0});

    foreach (tbl[t]) begin
      for (int n = 0; n < tbl[t].rep; n++) begin
        step(1'(tbl[t].rst), 1'(tbl[t].en), tbl[t].req, 1'(tbl[t].rdy));
        chk($sformatf("vec%0d_valid", t), 32'(v0), 32'(tbl[t].ev));
        chk($sformatf("vec%0d_pend", t), 32'(norm(p0)), 32'(tbl[t].ep));
        if (tbl[t].chkw != 0) chk($sformatf("vec%0d_W", t), 32'(w0), 32'(tbl[t].ew));
      end
    end

    // Full mask, fixed priority: 0..15 back-to-back
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16'h0, 1'b1);
      chk($sformatf("full_fixed_W%0d", i), 32'(w0), 32'(i));
      chk($sformatf("full_fixed_v%0d", i), 32'(v0), 32'd1);
    end
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("full_fixed_done", 32'(v0), 32'd0);

    // Round-robin wrap: grant 14, then {15,3,0} -> 15,0,3
    step(1'b1, 1'b1, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h4000, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_grant14", 32'(w1), 32'd14);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_idle14", 32'(v1), 32'd0);
    step(1'b0, 1'b1, 16'h8009, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_wrap15", 32'(w1), 32'd15);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_wrap0", 32'(w1), 32'd0);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_wrap3", 32'(w1), 32'd3);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("rr_wrap_done", 32'(v1), 32'd0);

    // Full mask, round robin with ptr=3: 4..15 then 0..3
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16'h0, 1'b1);
      chk($sformatf("full_rr_W%0d", i), 32'(w1), 32'((4 + i) % 16));
    end
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("full_rr_done", 32'(v1), 32'd0);

    // Reset mid-operation overrides capture and handshake
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("mid_pre_valid1", 32'(v1), 32'd1);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    chk("mid_rst_pend0",  32'(norm(p0)), 32'd0);
    chk("mid_rst_valid0", 32'(v0), 32'd0);
    chk("mid_rst_W0",     32'(w0), 32'd0);
    chk("mid_rst_pend1",  32'(norm(p1)), 32'd0);
    chk("mid_rst_valid1", 32'(v1), 32'd0);
    chk("mid_rst_W1",     32'(w1), 32'd0);
    step(1'b0, 1'b1, 16'h0001, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    chk("mid_rr_first0", 32'(w1), 32'd0);
    chk("mid_rr_valid",  32'(v1), 32'd1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] rq;
      rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 49) == 0) rq = 16'hFFFF;
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), rq,
           1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
